// File: rtl/mem_arbiter.sv
// Byte-serial RAM/IO port arbiter between instruction fetch and the load/store buffer.
// Accesses are split into 1-4 byte transfers; loads are reassembled and extended.
module mem_arbiter #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_grant,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_grant,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t      state_q;
    state_t      state_d;
    logic        owner_q;
    logic        last_owner_q;
    logic        sgn_q;
    logic        cap_vld_q;
    logic        prev_rdy_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [1:0]  size_q;
    logic [1:0]  cap_idx_q;
    logic [2:0]  nbytes_q;
    logic [2:0]  cnt_q;

    logic        if_ok;
    logic        ls_ok;
    logic        pick_ls;
    logic        accept;
    logic        reissue;
    logic        rd_issue;
    logic        capture;
    logic        last_cap;
    logic        io_stall;
    logic        wr_fire;
    logic        last_wr;
    logic [2:0]  ls_nbytes;
    logic [2:0]  nbytes_m1;

    // Arbitration: a flush blocks new reads, but a store is already committed.
    always_comb begin
        if_ok   = if_req & ~rollback;
        ls_ok   = ls_req & (ls_we | ~rollback);
        pick_ls = ls_ok & (~if_ok | (last_owner_q == OWN_IF));
        accept  = rst & rdy & (state_q == IDLE) & (if_ok | ls_ok);
        unique case (ls_size)
            2'd0:    ls_nbytes = 3'd1;
            2'd1:    ls_nbytes = 3'd2;
            default: ls_nbytes = 3'd4;
        endcase
    end

    // After a stall the read pipe lost the pending byte, so re-address it.
    always_comb begin
        nbytes_m1 = nbytes_q - 3'd1;
        reissue   = rdy & ~prev_rdy_q & cap_vld_q & (state_q == READ);
        rd_issue  = (state_q == READ) & (cnt_q < nbytes_q);
        capture   = rdy & (state_q == READ) & cap_vld_q & ~reissue;
        last_cap  = capture & ({1'b0, cap_idx_q} == nbytes_m1);
        io_stall  = (addr_q[17:16] == IO_HI) & io_buffer_full;
        wr_fire   = rdy & (state_q == WRITE) & ~io_stall;
        last_wr   = wr_fire & (cnt_q == nbytes_m1);
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (accept)
                        state_d = (pick_ls & ls_we) ? WRITE : READ;
                end
                READ: begin
                    if (rollback)
                        state_d = IDLE;
                    else if (last_cap)
                        state_d = DONE;
                end
                WRITE: begin
                    if (last_wr)
                        state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        if_grant = accept & ~pick_ls;
        ls_grant = accept & pick_ls;
        if_done  = (state_q == DONE) & (owner_q == OWN_IF);
        ls_done  = (state_q == DONE) & (owner_q == OWN_LS);
        if_data  = buf_q;
        mem_wr   = wr_fire;
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        if (state_q == WRITE) begin
            mem_a    = addr_q + {29'd0, cnt_q};
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end else if (reissue) begin
            mem_a = addr_q + {30'd0, cap_idx_q};
        end else if (rd_issue) begin
            mem_a = addr_q + {29'd0, cnt_q};
        end
    end

    always_comb begin
        unique case (size_q)
            2'd0:    ls_rdata = {{24{sgn_q & buf_q[7]}}, buf_q[7:0]};
            2'd1:    ls_rdata = {{16{sgn_q & buf_q[15]}}, buf_q[15:0]};
            default: ls_rdata = buf_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            sgn_q        <= 1'b0;
            cap_vld_q    <= 1'b0;
            prev_rdy_q   <= 1'b1;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            buf_q        <= 32'd0;
            size_q       <= 2'd0;
            cap_idx_q    <= 2'd0;
            nbytes_q     <= 3'd0;
            cnt_q        <= 3'd0;
        end else begin
            prev_rdy_q <= rdy;
            state_q    <= state_d;
            if (accept) begin
                owner_q   <= pick_ls;
                addr_q    <= pick_ls ? ls_addr : if_addr;
                size_q    <= pick_ls ? ls_size : 2'd2;
                sgn_q     <= pick_ls & ls_signed;
                wdata_q   <= ls_wdata;
                nbytes_q  <= pick_ls ? ls_nbytes : 3'd4;
                cnt_q     <= 3'd0;
                cap_vld_q <= 1'b0;
                cap_idx_q <= 2'd0;
                buf_q     <= 32'd0;
            end
            // Each read cycle captures the byte addressed the cycle before.
            if (rdy && (state_q == READ) && !reissue) begin
                if (capture)
                    buf_q[{cap_idx_q, 3'b000} +: 8] <= mem_din;
                cap_vld_q <= rd_issue;
                cap_idx_q <= cnt_q[1:0];
                if (rd_issue)
                    cnt_q <= cnt_q + 3'd1;
            end
            if (wr_fire)
                cnt_q <= cnt_q + 3'd1;
            if (rdy && (state_q == DONE))
                last_owner_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and a write log.
// Immediate assertions at each check; single summary line at the end.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_grant;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic        ls_signed = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_grant;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int ls_done_cnt = 0;

    logic [7:0]  ram [0:262143];
    logic [39:0] wlog [$];

    mem_arbiter #(.IO_HI(2'b11)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .rollback(rollback),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_grant(if_grant),
        .if_done(if_done),
        .if_data(if_data),
        .ls_req(ls_req),
        .ls_we(ls_we),
        .ls_size(ls_size),
        .ls_signed(ls_signed),
        .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_grant(ls_grant),
        .ls_done(ls_done),
        .ls_rdata(ls_rdata),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM: read data appears the cycle after its address; writes only logged.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr)
            wlog.push_back({mem_a, mem_dout});
        if (ls_done)
            ls_done_cnt <= ls_done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ls_issue(input logic we, input logic [1:0] sz,
                            input logic sg, input logic [31:0] a,
                            input logic [31:0] wd, input string tag);
        ls_req    = 1'b1;
        ls_we     = we;
        ls_size   = sz;
        ls_signed = sg;
        ls_addr   = a;
        ls_wdata  = wd;
        #1;
        chk({tag, " grant"}, {63'd0, ls_grant}, 64'd1);
    endtask

    task automatic wait_done(input bit lsb, input bit drop, input int exp_lat,
                             input string tag);
        int lat;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (lsb ? ls_done : if_done) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (drop) begin
            if (lsb)
                ls_req = 1'b0;
            else
                if_req = 1'b0;
        end
    endtask

    function automatic logic any_out();
        return |{if_grant, if_done, if_data, ls_grant, ls_done,
                 ls_rdata, mem_dout, mem_a, mem_wr};
    endfunction

    initial begin
        int base;
        int bad;
        int dbase;
        logic [7:0] swb [4];

        for (int i = 0; i < 262144; i++)
            ram[i] = 8'h00;
        ram[18'h100] = 8'h13;
        ram[18'h101] = 8'h05;
        ram[18'h102] = 8'h00;
        ram[18'h103] = 8'h00;
        ram[18'h200] = 8'h80;
        ram[18'h400] = 8'h11;
        ram[18'h401] = 8'h22;
        ram[18'h402] = 8'h33;
        ram[18'h403] = 8'h44;
        ram[18'h500] = 8'h34;
        ram[18'h501] = 8'hF2;
        ram[18'h3FFFE] = 8'hAA;
        ram[18'h3FFFF] = 8'hBB;
        ram[18'h00000] = 8'hCC;
        ram[18'h00001] = 8'hDD;

        tick();
        tick();
        #1;
        chk("reset outputs", {63'd0, any_out()}, 64'd0);
        rst = 1'b1;

        // fetch word
        if_addr = 32'h100;
        if_req  = 1'b1;
        #1;
        chk("fetch grant", {63'd0, if_grant}, 64'd1);
        chk("fetch no ls grant", {63'd0, ls_grant}, 64'd0);
        wait_done(1'b0, 1'b1, 6, "fetch");
        chk("fetch data", {32'd0, if_data}, 64'h0000_0513);

        // LB / LBU
        tick();
        ls_issue(1'b0, 2'd0, 1'b1, 32'h200, 32'd0, "lb");
        wait_done(1'b1, 1'b1, 3, "lb");
        chk("lb data", {32'd0, ls_rdata}, 64'hFFFF_FF80);
        tick();
        ls_issue(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, "lbu");
        wait_done(1'b1, 1'b1, 3, "lbu");
        chk("lbu data", {32'd0, ls_rdata}, 64'h0000_0080);

        // SW
        tick();
        base = wlog.size();
        ls_issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF, "sw");
        wait_done(1'b1, 1'b1, 5, "sw");
        chk("sw write count", 64'(wlog.size() - base), 64'd4);
        swb[0] = 8'hEF;
        swb[1] = 8'hBE;
        swb[2] = 8'hAD;
        swb[3] = 8'hDE;
        for (int i = 0; i < 4; i++)
            chk("sw byte", {24'd0, wlog[base + i]},
                {24'd0, 32'h300 + 32'(i), swb[i]});

        // both pending from reset: LSB first, then alternate
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_addr = 32'h100;
        if_req  = 1'b1;
        ls_issue(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, "arb ls");
        chk("arb fetch held", {63'd0, if_grant}, 64'd0);
        wait_done(1'b1, 1'b1, 3, "arb ls");
        tick();
        #1;
        chk("arb fetch next", {63'd0, if_grant}, 64'd1);
        ls_req = 1'b1;
        wait_done(1'b0, 1'b0, 6, "arb fetch");
        tick();
        #1;
        chk("alt ls grant", {62'd0, ls_grant, if_grant}, 64'b10);
        wait_done(1'b1, 1'b0, 3, "alt ls");
        tick();
        #1;
        chk("alt if grant", {62'd0, ls_grant, if_grant}, 64'b01);
        wait_done(1'b0, 1'b1, 6, "alt if");
        ls_req = 1'b0;

        // rollback in IDLE: load refused, store accepted
        tick();
        base = wlog.size();
        rollback  = 1'b1;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_size   = 2'd0;
        ls_addr   = 32'h340;
        ls_wdata  = 32'h77;
        #1;
        chk("rb idle load", {63'd0, ls_grant}, 64'd0);
        ls_we = 1'b1;
        #1;
        chk("rb idle store", {63'd0, ls_grant}, 64'd1);
        tick();
        rollback = 1'b0;
        wait_done(1'b1, 1'b1, 1, "rb idle store");
        chk("rb idle store wr", {24'd0, wlog[base]}, {24'd0, 32'h340, 8'h77});

        // IO stall
        tick();
        base = wlog.size();
        io_buffer_full = 1'b1;
        ls_issue(1'b1, 2'd0, 1'b0, 32'h30000, 32'h5A, "io sb");
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            if (mem_wr !== 1'b0)
                bad++;
        end
        chk("io stall wr", 64'(bad), 64'd0);
        tick();
        io_buffer_full = 1'b0;
        #1;
        chk("io write", {23'd0, mem_wr, mem_a, mem_dout},
            {23'd0, 1'b1, 32'h30000, 8'h5A});
        wait_done(1'b1, 1'b1, 1, "io sb");
        chk("io write count", 64'(wlog.size() - base), 64'd1);

        // rollback aborts LW
        tick();
        dbase = ls_done_cnt;
        ls_issue(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, "rb lw");
        tick();
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        ls_req   = 1'b0;
        if_addr  = 32'h100;
        if_req   = 1'b1;
        #1;
        chk("rb lw idle", {63'd0, if_grant}, 64'd1);
        wait_done(1'b0, 1'b1, 6, "rb fetch");
        chk("rb lw no done", 64'(ls_done_cnt - dbase), 64'd0);
        chk("rb fetch data", {32'd0, if_data}, 64'h0000_0513);

        // rollback during SH ignored
        tick();
        base = wlog.size();
        ls_issue(1'b1, 2'd1, 1'b0, 32'h310, 32'hABCD1234, "rb sh");
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        wait_done(1'b1, 1'b1, 1, "rb sh");
        chk("rb sh count", 64'(wlog.size() - base), 64'd2);
        chk("rb sh b0", {24'd0, wlog[base]}, {24'd0, 32'h310, 8'h34});
        chk("rb sh b1", {24'd0, wlog[base + 1]}, {24'd0, 32'h311, 8'h12});

        // rdy freeze in a signed LH
        tick();
        ls_issue(1'b0, 2'd1, 1'b1, 32'h500, 32'd0, "lh rdy");
        tick();
        tick();
        rdy = 1'b0;
        tick();
        tick();
        rdy = 1'b1;
        wait_done(1'b1, 1'b1, 3, "lh rdy");
        chk("lh rdy data", {32'd0, ls_rdata}, 64'hFFFF_F234);

        tick();
        ls_issue(1'b0, 2'd1, 1'b0, 32'h500, 32'd0, "lhu");
        wait_done(1'b1, 1'b1, 4, "lhu");
        chk("lhu data", {32'd0, ls_rdata}, 64'h0000_F234);

        // rdy freeze in a store
        tick();
        base = wlog.size();
        ls_issue(1'b1, 2'd0, 1'b0, 32'h330, 32'h99, "sb rdy");
        tick();
        rdy = 1'b0;
        #1;
        chk("sb rdy freeze", {63'd0, mem_wr}, 64'd0);
        tick();
        rdy = 1'b1;
        #1;
        chk("sb rdy resume", {63'd0, mem_wr}, 64'd1);
        wait_done(1'b1, 1'b1, 1, "sb rdy");
        chk("sb rdy count", 64'(wlog.size() - base), 64'd1);

        // unaligned LW wrapping past 2^32
        tick();
        ls_issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'd0, "lw wrap");
        wait_done(1'b1, 1'b1, 6, "lw wrap");
        chk("lw wrap data", {32'd0, ls_rdata}, 64'hDDCC_BBAA);

        // reset in the middle of a store
        tick();
        ls_issue(1'b1, 2'd2, 1'b0, 32'h320, 32'h01020304, "rst sw");
        tick();
        tick();
        rst = 1'b0;
        tick();
        #1;
        chk("rst mem_wr", {63'd0, mem_wr}, 64'd0);
        chk("rst outputs", {63'd0, any_out()}, 64'd0);
        rst    = 1'b1;
        ls_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO port.
- Shares that port between two requesters: the instruction fetch unit (32-bit word reads) and the load/store buffer (LB/LH/LW/LBU/LHU loads, SB/SH/SW stores).
- Each access is serialised into 1–4 byte transfers. Load data is reassembled and sign/zero-extended, then returned with a one-cycle done pulse.
- Sits between the fetch/LSB front end and the top-level RAM/IO bus.

Parameters:
- IO_HI, 2'b11, value of addr[17:16] that selects the IO region (write stall on io_buffer_full).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rdy  in  1  global enable; 0 freezes all state, mem_wr forced 0
- rollback  in  1  misprediction flush
- if_req  in  1  fetch request (level, held until if_done)
- if_addr  in  32  fetch word address
- if_grant  out  1  one-cycle pulse: fetch accepted
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word, little-endian
- ls_req  in  1  LSB request (level, held until ls_done)
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  0 = byte, 1 = half, 2 = word (3 illegal, treated as word)
- ls_signed  in  1  sign-extend load result
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, low bytes used
- ls_grant  out  1  one-cycle pulse: LSB access accepted
- ls_done  out  1  one-cycle pulse: load data valid / store complete
- ls_rdata  out  32  extended load result
- mem_din  in  8  RAM read byte (valid the cycle after its address)
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO output FIFO full

Behaviour:
- Reset (rst=0 at clk edge) returns to IDLE and clears the following: every output 0, the byte counter, the assembly buffer, and last_owner (reset value = fetch).
- States: IDLE, READ, WRITE, DONE.

IDLE arbitration:
- If both requesters are pending, the one not equal to last_owner wins. If only one is pending, it wins.
- On accept: pulse the grant, latch addr/size/signed/wdata/owner, set cnt=0, enter READ or WRITE.
- With rollback=1 in IDLE, no new load/fetch is accepted that cycle; a store may still be accepted.

READ (N bytes: fetch=4, LSB=1<<size):
- Cycle k (k=0..N-1): mem_a=addr+k, mem_wr=0.
- mem_din captured in cycle k+1 into byte k of the buffer.
- After byte N-1 is captured, go to DONE.
- Total: grant at T, bytes addressed T+1..T+N, done pulse at T+N+2.

WRITE:
- Cycle k: mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
- If addr[17:16]==IO_HI and io_buffer_full=1, that cycle drives mem_wr=0 and cnt holds.
- After byte N-1, go to DONE. Done pulse at T+N+1 when unstalled.

DONE:
- Pulse the owner's done for one cycle. if_data = buffer.
- ls_rdata: byte/half sign-extended when ls_signed=1, else zero-extended.
- Set last_owner, return to IDLE. The next grant can occur the following cycle.

Rollback:
- During READ: abort immediately to IDLE, no done pulse, buffer discarded.
- During WRITE: ignored; the store completes and pulses ls_done (committed stores are never dropped).

Other rules:
- rdy=0: state, counters and outputs hold, except mem_wr=0. The byte whose address is issued on the first rdy=1 cycle is re-addressed.
- Requests deasserting mid-transfer do not abort the transfer.
- Address arithmetic is mod 2^32. Unaligned accesses are handled byte-serially without faulting.

Test Plan:
- Fetch only, if_addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> if_grant at T, if_done at T+6, if_data=0x00000513.
- LB addr=0x200, RAM=0x80, signed=1 -> ls_rdata=0xFFFFFF80. Same access with LBU -> 0x00000080; ls_done at T+3.
- SW addr=0x300, wdata=0xDEADBEEF -> mem_wr for 4 cycles, bytes EF, BE, AD, DE at 0x300..0x303; ls_done at T+5.
- if_req and ls_req asserted together from reset (last_owner=fetch) -> LSB granted first, fetch granted the cycle after ls_done. Repeat with both held -> grants alternate.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles, single write once cleared, ls_done after.
- Rollback at cycle 2 of an LW -> no ls_done, IDLE next cycle. Rollback during an SH -> both bytes written, ls_done asserted. rst=0 mid-WRITE -> mem_wr=0 at the next edge, all outputs 0.
